// File: rtl/operand_load_ctrl.sv
// Operand capture and sequencing for a keypad-driven FP16 add/subtract unit.
// Debounces three active-low push buttons and turns presses into operand loads and result requests.
module operand_load_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        LoadA,
   input  logic        LoadB,
   input  logic        LoadR,
   input  logic        OpSel,
   input  logic [15:0] KeyValue,
   input  logic        Done,
   input  logic [15:0] Result,
   output logic [15:0] A,
   output logic [15:0] B,
   output logic        Op,
   output logic        Start,
   output logic [15:0] DisplayValue,
   output logic        Busy,
   output logic        Err
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_SHOW = 2'd2
   } state_t;

   // Button index 0 = LoadA, 1 = LoadB, 2 = LoadR; lower index wins on simultaneous presses.
   logic [2:0]    btn_s;
   logic [2:0]    sync1_r;
   logic [2:0]    sync2_r;
   logic [2:0]    level_r;
   logic [2:0]    level_d_r;
   logic [2:0]    press_s;
   logic [CW-1:0] cnt_r [3];

   state_t        state_r;
   state_t        state_nxt_s;
   logic [15:0]   a_r;
   logic [15:0]   a_nxt_s;
   logic [15:0]   b_r;
   logic [15:0]   b_nxt_s;
   logic [15:0]   res_r;
   logic [15:0]   res_nxt_s;
   logic          av_r;
   logic          av_nxt_s;
   logic          bv_r;
   logic          bv_nxt_s;
   logic          op_r;
   logic          op_nxt_s;
   logic          err_r;
   logic          err_nxt_s;
   logic          start_r;
   logic          start_nxt_s;
   logic          busy_r;

   assign btn_s   = {LoadR, LoadB, LoadA};
   assign press_s = level_d_r & ~level_r;

   // Two-flop synchronizer; resets to the released level.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync1_r <= 3'b111;
         sync2_r <= 3'b111;
      end else begin
         sync1_r <= btn_s;
         sync2_r <= sync1_r;
      end
   end

   // Debouncer: accept a new level only after it has been stable for the full count.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         level_r   <= 3'b111;
         level_d_r <= 3'b111;
         for (int i = 0; i < 3; i++) begin
            cnt_r[i] <= {CW{1'b0}};
         end
      end else begin
         level_d_r <= level_r;
         for (int i = 0; i < 3; i++) begin
            if (sync2_r[i] != level_r[i]) begin
               if (cnt_r[i] == CNT_MAX) begin
                  level_r[i] <= sync2_r[i];
                  cnt_r[i]   <= {CW{1'b0}};
               end else begin
                  cnt_r[i] <= cnt_r[i] + CW'(1);
               end
            end else begin
               cnt_r[i] <= {CW{1'b0}};
            end
         end
      end
   end

   // Next-state and datapath update for the IDLE/BUSY/SHOW sequencer.
   always_comb begin
      state_nxt_s = state_r;
      a_nxt_s     = a_r;
      b_nxt_s     = b_r;
      res_nxt_s   = res_r;
      av_nxt_s    = av_r;
      bv_nxt_s    = bv_r;
      op_nxt_s    = op_r;
      err_nxt_s   = err_r;
      start_nxt_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_SHOW: begin
            if (press_s[0]) begin
               a_nxt_s     = KeyValue;
               av_nxt_s    = 1'b1;
               err_nxt_s   = 1'b0;
               state_nxt_s = ST_IDLE;
            end else if (press_s[1]) begin
               b_nxt_s     = KeyValue;
               bv_nxt_s    = 1'b1;
               err_nxt_s   = 1'b0;
               state_nxt_s = ST_IDLE;
            end else if (press_s[2]) begin
               if (av_r && bv_r) begin
                  start_nxt_s = 1'b1;
                  op_nxt_s    = OpSel;
                  err_nxt_s   = 1'b0;
                  state_nxt_s = ST_BUSY;
               end else begin
                  err_nxt_s = 1'b1;
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_BUSY: begin
            // Presses are dropped here; only Done moves the sequencer on.
            if (Done) begin
               res_nxt_s   = Result;
               state_nxt_s = ST_SHOW;
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_r <= ST_IDLE;
         a_r     <= 16'h0000;
         b_r     <= 16'h0000;
         res_r   <= 16'h0000;
         av_r    <= 1'b0;
         bv_r    <= 1'b0;
         op_r    <= 1'b0;
         err_r   <= 1'b0;
         start_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         a_r     <= a_nxt_s;
         b_r     <= b_nxt_s;
         res_r   <= res_nxt_s;
         av_r    <= av_nxt_s;
         bv_r    <= bv_nxt_s;
         op_r    <= op_nxt_s;
         err_r   <= err_nxt_s;
         start_r <= start_nxt_s;
         busy_r  <= (state_nxt_s == ST_BUSY);
      end
   end

   assign A            = a_r;
   assign B            = b_r;
   assign Op           = op_r;
   assign Start        = start_r;
   assign Busy         = busy_r;
   assign Err          = err_r;
   assign DisplayValue = (state_r == ST_SHOW) ? res_r : KeyValue;

endmodule

// File: tb/tb_operand_load_ctrl.sv
// Directed bench for operand_load_ctrl with a short debounce window.
module tb_operand_load_ctrl;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        LoadA = 1'b1;
   logic        LoadB = 1'b1;
   logic        LoadR = 1'b1;
   logic        OpSel = 1'b0;
   logic [15:0] KeyValue = 16'h0000;
   logic        Done = 1'b0;
   logic [15:0] Result = 16'h0000;
   logic [15:0] A;
   logic [15:0] B;
   logic        Op;
   logic        Start;
   logic [15:0] DisplayValue;
   logic        Busy;
   logic        Err;

   int checks = 0;
   int failures = 0;
   int start_cnt = 0;
   logic start_prev = 1'b0;
   logic double_start = 1'b0;

   operand_load_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .Clock(Clock), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB), .LoadR(LoadR),
      .OpSel(OpSel), .KeyValue(KeyValue), .Done(Done), .Result(Result),
      .A(A), .B(B), .Op(Op), .Start(Start), .DisplayValue(DisplayValue),
      .Busy(Busy), .Err(Err)
   );

   always #5 Clock = ~Clock;

   // Counts Start pulses and flags any back-to-back pair.
   always @(negedge Clock) begin
      if (Start) start_cnt = start_cnt + 1;
      if (Start && start_prev) double_start = 1'b1;
      start_prev = Start;
   end

   task automatic clocks(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic press(input int which, input int hold);
      if (which == 0) LoadA = 1'b0;
      else if (which == 1) LoadB = 1'b0;
      else LoadR = 1'b0;
      clocks(hold);
      LoadA = 1'b1;
      LoadB = 1'b1;
      LoadR = 1'b1;
      clocks(10);
   endtask

   task automatic wait_start(output logic seen);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         clocks(1);
         if (Start) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      KeyValue = 16'h1357;
      clocks(2);
      checks++;
      if ({A, B, Op, Start, Busy, Err} !== {16'h0000, 16'h0000, 4'b0000}) begin
         failures++;
         $display("FAIL reset_outputs: got A=%h B=%h Op=%b Start=%b Busy=%b Err=%b, want all zero",
                  A, B, Op, Start, Busy, Err);
      end
      checks++;
      if (DisplayValue !== 16'h1357) begin
         failures++;
         $display("FAIL reset_display: got %h want 1357", DisplayValue);
      end
      Reset = 1'b1;
      clocks(2);
   endtask

   task automatic test_load_a;
      KeyValue = 16'h3C00;
      LoadA = 1'b0;
      clocks(6);
      checks++;
      if (A !== 16'h0000) begin
         failures++;
         $display("FAIL load_a_early: got %h want 0000", A);
      end
      clocks(1);
      checks++;
      if (A !== 16'h3C00) begin
         failures++;
         $display("FAIL load_a_capture: got %h want 3c00", A);
      end
      checks++;
      if (DisplayValue !== 16'h3C00) begin
         failures++;
         $display("FAIL load_a_display: got %h want 3c00", DisplayValue);
      end
      clocks(3);
      LoadA = 1'b1;
      clocks(10);
   endtask

   task automatic test_bounce;
      KeyValue = 16'h1234;
      for (int i = 0; i < 5; i++) begin
         LoadA = 1'b0;
         clocks(2);
         LoadA = 1'b1;
         clocks(2);
      end
      clocks(10);
      checks++;
      if (A !== 16'h3C00) begin
         failures++;
         $display("FAIL bounce_ignored: got %h want 3c00", A);
      end
   endtask

   task automatic test_subtract;
      int base;
      logic seen;
      KeyValue = 16'h4000;
      press(1, 10);
      checks++;
      if (B !== 16'h4000) begin
         failures++;
         $display("FAIL load_b: got %h want 4000", B);
      end
      OpSel = 1'b1;
      base = start_cnt;
      LoadR = 1'b0;
      wait_start(seen);
      checks++;
      if (seen !== 1'b1) begin
         failures++;
         $display("FAIL sub_start_timeout: got no Start want one");
      end
      checks++;
      if ({Op, Busy} !== 2'b11) begin
         failures++;
         $display("FAIL sub_op_busy: got Op=%b Busy=%b want 1 1", Op, Busy);
      end
      clocks(1);
      checks++;
      if (Start !== 1'b0) begin
         failures++;
         $display("FAIL sub_start_width: got %b want 0", Start);
      end
      clocks(1);
      Done = 1'b1;
      Result = 16'hBC00;
      clocks(1);
      Done = 1'b0;
      Result = 16'h0000;
      checks++;
      if ({DisplayValue, Busy} !== {16'hBC00, 1'b0}) begin
         failures++;
         $display("FAIL sub_show: got disp=%h Busy=%b want bc00 0", DisplayValue, Busy);
      end
      LoadR = 1'b1;
      clocks(10);
      checks++;
      if (start_cnt !== base + 1) begin
         failures++;
         $display("FAIL sub_start_count: got %0d want %0d", start_cnt - base, 1);
      end
   endtask

   task automatic test_show_reissue;
      logic seen;
      OpSel = 1'b0;
      KeyValue = 16'h7E00;
      LoadR = 1'b0;
      wait_start(seen);
      checks++;
      if ({seen, Op, Busy} !== 3'b101) begin
         failures++;
         $display("FAIL reissue_start: got seen=%b Op=%b Busy=%b want 1 0 1", seen, Op, Busy);
      end
      LoadR = 1'b1;
      press(0, 10);
      checks++;
      if ({A, Busy} !== {16'h3C00, 1'b1}) begin
         failures++;
         $display("FAIL busy_ignores_press: got A=%h Busy=%b want 3c00 1", A, Busy);
      end
      Done = 1'b1;
      Result = 16'h4200;
      clocks(1);
      Done = 1'b0;
      checks++;
      if (DisplayValue !== 16'h4200) begin
         failures++;
         $display("FAIL reissue_show: got %h want 4200", DisplayValue);
      end
      KeyValue = 16'h3800;
      press(0, 10);
      checks++;
      if ({A, DisplayValue} !== {16'h3800, 16'h3800}) begin
         failures++;
         $display("FAIL show_to_idle: got A=%h disp=%h want 3800 3800", A, DisplayValue);
      end
      Done = 1'b1;
      Result = 16'hFFFF;
      clocks(1);
      Done = 1'b0;
      clocks(1);
      checks++;
      if ({DisplayValue, Busy} !== {16'h3800, 1'b0}) begin
         failures++;
         $display("FAIL idle_done_ignored: got disp=%h Busy=%b want 3800 0", DisplayValue, Busy);
      end
   endtask

   task automatic test_err;
      int base;
      Reset = 1'b0;
      clocks(1);
      Reset = 1'b1;
      clocks(2);
      KeyValue = 16'h1111;
      press(0, 10);
      base = start_cnt;
      press(2, 10);
      checks++;
      if ({Err, Busy} !== 2'b10 || start_cnt !== base) begin
         failures++;
         $display("FAIL err_set: got Err=%b Busy=%b starts=%0d want 1 0 0", Err, Busy, start_cnt - base);
      end
      KeyValue = 16'h2222;
      press(1, 10);
      checks++;
      if ({Err, B} !== {1'b0, 16'h2222}) begin
         failures++;
         $display("FAIL err_clear: got Err=%b B=%h want 0 2222", Err, B);
      end
   endtask

   task automatic test_priority;
      int base;
      base = start_cnt;
      KeyValue = 16'h7777;
      LoadA = 1'b0;
      LoadR = 1'b0;
      clocks(10);
      LoadA = 1'b1;
      LoadR = 1'b1;
      clocks(10);
      checks++;
      if ({A, Busy, Err} !== {16'h7777, 2'b00} || start_cnt !== base) begin
         failures++;
         $display("FAIL priority_a_over_r: got A=%h Busy=%b Err=%b starts=%0d want 7777 0 0 0",
                  A, Busy, Err, start_cnt - base);
      end
   endtask

   task automatic test_reset_busy;
      logic seen;
      OpSel = 1'b1;
      KeyValue = 16'h0F0F;
      LoadR = 1'b0;
      wait_start(seen);
      checks++;
      if ({seen, Busy} !== 2'b11) begin
         failures++;
         $display("FAIL rst_busy_enter: got seen=%b Busy=%b want 1 1", seen, Busy);
      end
      LoadR = 1'b1;
      clocks(2);
      Reset = 1'b0;
      #1;
      checks++;
      if ({Busy, Op, A} !== {2'b00, 16'h0000}) begin
         failures++;
         $display("FAIL rst_async: got Busy=%b Op=%b A=%h want 0 0 0000", Busy, Op, A);
      end
      clocks(1);
      Reset = 1'b1;
      clocks(2);
      Done = 1'b1;
      Result = 16'hABCD;
      clocks(1);
      Done = 1'b0;
      clocks(10);
      checks++;
      if ({A, B, Op, Start, Busy, Err, DisplayValue} !== {16'h0000, 16'h0000, 4'b0000, 16'h0F0F}) begin
         failures++;
         $display("FAIL rst_busy_done: got A=%h B=%h Op=%b Start=%b Busy=%b Err=%b disp=%h want zeros disp=0f0f",
                  A, B, Op, Start, Busy, Err, DisplayValue);
      end
   endtask

   task automatic test_held_through_reset;
      KeyValue = 16'h5A5A;
      LoadA = 1'b0;
      clocks(3);
      Reset = 1'b0;
      clocks(1);
      Reset = 1'b1;
      clocks(12);
      checks++;
      if (A !== 16'h5A5A) begin
         failures++;
         $display("FAIL held_reset_event: got %h want 5a5a", A);
      end
      KeyValue = 16'h0001;
      clocks(10);
      LoadA = 1'b1;
      clocks(10);
      checks++;
      if (A !== 16'h5A5A) begin
         failures++;
         $display("FAIL held_reset_single: got %h want 5a5a", A);
      end
   endtask

   task automatic test_start_spacing;
      checks++;
      if (double_start !== 1'b0) begin
         failures++;
         $display("FAIL start_spacing: got back-to-back Start=%b want 0", double_start);
      end
   endtask

   initial begin
      test_reset();
      test_load_a();
      test_bounce();
      test_subtract();
      test_show_reissue();
      test_err();
      test_priority();
      test_reset_busy();
      test_held_through_reset();
      test_start_spacing();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
